// File: rtl/branch_target_buffer.sv
// branch_target_buffer
//   Direct-mapped branch target buffer with a 2-bit saturating direction
//   counter per entry. The fetch stage looks up its PC and gets a taken
//   prediction and target in the same cycle. The decode stage, where branches
//   resolve, trains the table and reports mispredictions to a saturating
//   performance counter.
//
// Ports
//   clk              core clock, rising edge
//   reset_n          asynchronous active-low reset
//   lookup_pc        fetch PC
//   pred_taken       predicted taken for lookup_pc
//   pred_target      predicted target, 0 when pred_taken is low
//   upd_valid        resolved branch/jump present this cycle
//   upd_pc           PC of the resolved branch
//   upd_taken        actual direction
//   upd_target       actual target
//   upd_pred_taken   prediction made for this branch at fetch
//   upd_pred_target  target predicted at fetch
//   invalidate       clear all entries (fence.i / self-modifying code)
//   mispredict       combinational, high when the resolved branch was mispredicted
//   mispredict_cnt   saturating count of mispredictions
module branch_target_buffer #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    input  logic             invalidate,
    output logic             mispredict,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] CTR_WEAK_T  = 2'b10;

    logic [ENTRIES-1:0] valid;
    logic [1:0]         ctr        [ENTRIES];
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [XLEN-3:0]    target_mem [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             do_update;

    // Targets are word aligned, so the low PC/target bits never reach storage.
    logic unused_low_bits;
    assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    // ---------------------------------------------------------------- lookup
    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign lk_hit = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);

    // Reads registered state only: a same-cycle update is not forwarded.
    assign pred_taken  = lk_hit && ctr[lk_idx][1];
    assign pred_target = pred_taken ? {target_mem[lk_idx], 2'b00} : '0;

    // ---------------------------------------------------------------- update
    assign up_idx    = upd_pc[IDX_W+1:2];
    assign up_tag    = upd_pc[XLEN-1:IDX_W+2];
    assign up_hit    = valid[up_idx] && (tag_mem[up_idx] == up_tag);
    assign do_update = upd_valid && !invalidate;

    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

    // Valid bits and direction counters carry reset state.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is assigned with <= so every register samples
        // pre-edge values regardless of statement order.
        if (!reset_n) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_WEAK_NT;
        end else if (invalidate) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_WEAK_NT;
        end else if (do_update) begin
            if (up_hit) begin
                if (upd_taken) begin
                    ctr[up_idx] <= (ctr[up_idx] == 2'b11) ? 2'b11 : ctr[up_idx] + 2'd1;
                end else begin
                    ctr[up_idx] <= (ctr[up_idx] == 2'b00) ? 2'b00 : ctr[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid[up_idx] <= 1'b1;
                ctr[up_idx]   <= CTR_WEAK_T;
            end
        end
    end

    // NOTE: tag/target storage has no reset; entries are qualified by valid,
    // which keeps the arrays mappable to plain RAM.
    // Any taken update either refreshes a hit's target or allocates the entry;
    // rewriting the tag on a hit stores the same value.
    always_ff @(posedge clk) begin
        if (do_update && upd_taken) begin
            tag_mem[up_idx]    <= up_tag;
            target_mem[up_idx] <= upd_target[XLEN-1:2];
        end
    end

    // ------------------------------------------------ mispredict perf counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mispredict_cnt <= '0;
        end else if (mispredict && (mispredict_cnt != '1)) begin
            mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 4;

    logic             clk;
    logic             reset_n;
    logic [XLEN-1:0]  lookup_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_pred_taken;
    logic [XLEN-1:0]  upd_pred_target;
    logic             invalidate;
    logic             mispredict;
    logic [CNT_W-1:0] mispredict_cnt;

    int checks = 0;
    int passed = 0;

    branch_target_buffer #(
        .XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .lookup_pc(lookup_pc),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .upd_valid(upd_valid),
        .upd_pc(upd_pc),
        .upd_taken(upd_taken),
        .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .invalidate(invalidate),
        .mispredict(mispredict),
        .mispredict_cnt(mispredict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [XLEN-1:0] pc);
        lookup_pc = pc;
        #1;
    endtask

    task automatic set_upd(input logic [XLEN-1:0] pc, input logic taken,
                           input logic [XLEN-1:0] tgt, input logic ptaken,
                           input logic [XLEN-1:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = taken;
        upd_target      = tgt;
        upd_pred_taken  = ptaken;
        upd_pred_target = ptgt;
        #1;
    endtask

    task automatic clr_upd();
        upd_valid       = 1'b0;
        upd_taken       = 1'b0;
        upd_pred_taken  = 1'b0;
        invalidate      = 1'b0;
        #1;
    endtask

    // One edge with an update applied, then bus idle again.
    task automatic do_upd(input logic [XLEN-1:0] pc, input logic taken,
                          input logic [XLEN-1:0] tgt, input logic ptaken,
                          input logic [XLEN-1:0] ptgt);
        set_upd(pc, taken, tgt, ptaken, ptgt);
        tick();
        clr_upd();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clr_upd();
        upd_pc = '0; upd_target = '0; upd_pred_target = '0;
        look(32'h0000_0040);
        #10;
        reset_n = 1'b1;
        tick();
        look(32'h0000_0040);
        checks++; if (pred_taken !== 1'b0) $display("FAIL reset_pred_taken: got %0b want 0", pred_taken); else passed++;
        checks++; if (pred_target !== 32'h0) $display("FAIL reset_pred_target: got %h want 0", pred_target); else passed++;
        checks++; if (mispredict_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", mispredict_cnt); else passed++;
    endtask

    task automatic test_allocate();
        set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        checks++; if (mispredict !== 1'b1) $display("FAIL alloc_mispredict: got %0b want 1", mispredict); else passed++;
        tick();
        clr_upd();
        checks++; if (mispredict_cnt !== 4'd1) $display("FAIL alloc_cnt: got %0d want 1", mispredict_cnt); else passed++;
        look(32'h40);
        checks++; if (pred_taken !== 1'b1) $display("FAIL alloc_pred_taken: got %0b want 1", pred_taken); else passed++;
        checks++; if (pred_target !== 32'h100) $display("FAIL alloc_pred_target: got %h want 00000100", pred_target); else passed++;
    endtask

    task automatic test_hysteresis();
        // ctr 10 -> 01
        do_upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        look(32'h40);
        checks++; if (pred_taken !== 1'b0) $display("FAIL hyst_weak_nt_taken: got %0b want 0", pred_taken); else passed++;
        checks++; if (pred_target !== 32'h0) $display("FAIL hyst_weak_nt_target: got %h want 0", pred_target); else passed++;
        // ctr 01 -> 10 -> 11
        do_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        set_upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        checks++; if (mispredict !== 1'b0) $display("FAIL hyst_correct_mispredict: got %0b want 0", mispredict); else passed++;
        tick();
        clr_upd();
        // ctr 11 -> 10, still taken
        do_upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        look(32'h40);
        checks++; if (pred_taken !== 1'b1) $display("FAIL hyst_strong_taken: got %0b want 1", pred_taken); else passed++;
        checks++; if (pred_target !== 32'h100) $display("FAIL hyst_strong_target: got %h want 00000100", pred_target); else passed++;
        checks++; if (mispredict_cnt !== 4'd4) $display("FAIL hyst_cnt: got %0d want 4", mispredict_cnt); else passed++;
    endtask

    task automatic test_alias();
        // 0x440 shares index 0 with 0x40 but has a different tag.
        lookup_pc = 32'h440;
        set_upd(32'h440, 1'b1, 32'h200, 1'b0, 32'h0);
        checks++; if (pred_taken !== 1'b0) $display("FAIL alias_no_bypass: got %0b want 0", pred_taken); else passed++;
        tick();
        clr_upd();
        look(32'h40);
        checks++; if (pred_taken !== 1'b0) $display("FAIL alias_old_miss: got %0b want 0", pred_taken); else passed++;
        look(32'h440);
        checks++; if (pred_taken !== 1'b1) $display("FAIL alias_new_hit: got %0b want 1", pred_taken); else passed++;
        checks++; if (pred_target !== 32'h200) $display("FAIL alias_new_target: got %h want 00000200", pred_target); else passed++;
        // Not-taken miss must not allocate.
        do_upd(32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
        look(32'h80);
        checks++; if (pred_taken !== 1'b0) $display("FAIL nt_miss_no_alloc: got %0b want 0", pred_taken); else passed++;
        checks++; if (mispredict_cnt !== 4'd5) $display("FAIL alias_cnt: got %0d want 5", mispredict_cnt); else passed++;
    endtask

    task automatic test_invalidate();
        invalidate = 1'b1;
        set_upd(32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
        tick();
        clr_upd();
        look(32'h440);
        checks++; if (pred_taken !== 1'b0) $display("FAIL inv_clears: got %0b want 0", pred_taken); else passed++;
        look(32'h80);
        checks++; if (pred_taken !== 1'b0) $display("FAIL inv_drops_update: got %0b want 0", pred_taken); else passed++;
        checks++; if (mispredict_cnt !== 4'd6) $display("FAIL inv_cnt: got %0d want 6", mispredict_cnt); else passed++;
        // Re-allocate, then reset asynchronously between edges.
        do_upd(32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
        look(32'h80);
        checks++; if (pred_target !== 32'h300) $display("FAIL realloc_target: got %h want 00000300", pred_target); else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (pred_taken !== 1'b0) $display("FAIL async_rst_pred: got %0b want 0", pred_taken); else passed++;
        checks++; if (mispredict_cnt !== 4'd0) $display("FAIL async_rst_cnt: got %0d want 0", mispredict_cnt); else passed++;
        #1;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 20; i++) begin
            do_upd(32'hC0, 1'b0, 32'h0, 1'b1, 32'h500);
            if (i == 15) begin
                checks++; if (mispredict_cnt !== 4'd15) $display("FAIL sat_reach: got %0d want 15", mispredict_cnt); else passed++;
            end
        end
        checks++; if (mispredict_cnt !== 4'd15) $display("FAIL sat_hold: got %0d want 15", mispredict_cnt); else passed++;
        set_upd(32'h40, 1'b1, 32'h104, 1'b1, 32'h100);
        checks++; if (mispredict !== 1'b1) $display("FAIL wrong_target: got %0b want 1", mispredict); else passed++;
        set_upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        checks++; if (mispredict !== 1'b0) $display("FAIL right_target: got %0b want 0", mispredict); else passed++;
        upd_valid = 1'b0;
        upd_pred_taken = 1'b0;
        #1;
        checks++; if (mispredict !== 1'b0) $display("FAIL idle_mispredict: got %0b want 0", mispredict); else passed++;
        clr_upd();
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_hysteresis();
        test_alias();
        test_invalidate();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
